// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Bimodal branch predictor for a 5-stage pipeline. A table of 2^IDX_W
// two-bit saturating counters is indexed by the low bits of the fetch PC.
// The IF-stage prediction is the counter MSB, qualified by if_is_branch.
// The prediction and table index travel down two pipeline slots:
// D (IF/ID) and E (ID/EX). When the branch resolves in EX, the counter it
// was predicted from is trained, and resolved/mispredicted counts are kept.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   if_pc          word-addressed PC of the instruction in IF
//   if_instr       fetched instruction, [15:0] is the signed branch offset
//   if_is_branch   fetched instruction is a conditional branch
//   stall          pipeline hold, D and E keep their contents
//   flush          EX redirect, kills D and E (wins over stall)
//   taken          EX branch resolved taken
//   not_taken      EX branch resolved not taken
//   pred_taken_if  IF-stage prediction (combinational)
//   pred_target    if_pc + 1 + sign-extended offset (combinational)
//   ex_pred_taken  prediction that belongs to the instruction now in EX
//   br_cnt         resolved-branch count, saturating
//   mispred_cnt    mispredicted-branch count, saturating
//
// Handshake: there is no valid/ready pair. A resolution is consumed in
// exactly the cycle it is presented. It trains the table only if E holds
// a valid branch, stall is low and exactly one of taken/not_taken is high.
// A taken/not_taken pair that disagrees is ignored.
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   input  logic        if_is_branch,
   input  logic        stall,
   input  logic        flush,
   input  logic        taken,
   input  logic        not_taken,
   output logic        pred_taken_if,
   output logic [31:0] pred_target,
   output logic        ex_pred_taken,
   output logic [15:0] br_cnt,
   output logic [15:0] mispred_cnt
);

   localparam int DEPTH = 1 << IDX_W;

   // Counter table: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
   logic [1:0]       r_table [DEPTH];

   // D slot (IF/ID)
   logic             r_d_valid;
   logic             r_d_br;
   logic             r_d_pred;
   logic [IDX_W-1:0] r_d_idx;

   // E slot (ID/EX)
   logic             r_e_valid;
   logic             r_e_br;
   logic             r_e_pred;
   logic [IDX_W-1:0] r_e_idx;

   logic [15:0]      r_br_cnt;
   logic [15:0]      r_mis_cnt;

   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_rd_entry;
   logic [1:0]       w_old;
   logic [1:0]       w_new;
   logic             w_upd;
   logic             w_mispred;
   logic [31:0]      w_offset;
   logic             w_unused;

   // ------------------------------------------------------------------
   // IF-stage lookup. The read is asynchronous and sees the value stored
   // before this edge, so a same-index update in EX is not bypassed.
   // ------------------------------------------------------------------
   assign w_idx         = if_pc[IDX_W-1:0];
   assign w_rd_entry    = r_table[w_idx];
   assign pred_taken_if = if_is_branch & w_rd_entry[1];

   assign w_offset    = {{16{if_instr[15]}}, if_instr[15:0]};
   assign pred_target = if_pc + 32'd1 + w_offset;

   // Opcode bits are not needed here.
   assign w_unused = &{1'b0, if_instr[31:16]};

   // ------------------------------------------------------------------
   // EX-stage training
   // ------------------------------------------------------------------
   assign ex_pred_taken = r_e_valid & r_e_br & r_e_pred;

   // flush does not gate the update: the EX instruction itself survives.
   assign w_upd     = r_e_valid & r_e_br & ~stall & (taken ^ not_taken);
   assign w_mispred = (r_e_pred != taken);
   assign w_old     = r_table[r_e_idx];

   always_comb begin
      w_new = w_old;
      if (taken) begin
         if (w_old != 2'd3) w_new = w_old + 2'd1;
      end else begin
         if (w_old != 2'd0) w_new = w_old - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_table[i] <= 2'b01;
      end else if (w_upd) begin
         r_table[r_e_idx] <= w_new;
      end
   end

   // ------------------------------------------------------------------
   // Pipeline slots
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_valid <= 1'b0;
         r_d_br    <= 1'b0;
         r_d_pred  <= 1'b0;
         r_d_idx   <= '0;
         r_e_valid <= 1'b0;
         r_e_br    <= 1'b0;
         r_e_pred  <= 1'b0;
         r_e_idx   <= '0;
      end else if (flush) begin
         // Only valid needs clearing; stale payload is never consumed.
         r_d_valid <= 1'b0;
         r_e_valid <= 1'b0;
      end else if (!stall) begin
         r_d_valid <= 1'b1;
         r_d_br    <= if_is_branch;
         r_d_pred  <= pred_taken_if;
         r_d_idx   <= w_idx;
         r_e_valid <= r_d_valid;
         r_e_br    <= r_d_br;
         r_e_pred  <= r_d_pred;
         r_e_idx   <= r_d_idx;
      end
   end

   // ------------------------------------------------------------------
   // Statistics counters, saturating at all-ones
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_cnt  <= '0;
         r_mis_cnt <= '0;
      end else if (w_upd) begin
         if (r_br_cnt != 16'hFFFF) r_br_cnt <= r_br_cnt + 16'd1;
         if (w_mispred && (r_mis_cnt != 16'hFFFF)) r_mis_cnt <= r_mis_cnt + 16'd1;
      end
   end

   assign br_cnt      = r_br_cnt;
   assign mispred_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int IDX_W = 6;
   localparam int DEPTH = 64;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_is_branch;
   logic        stall;
   logic        flush;
   logic        taken;
   logic        not_taken;
   logic        pred_taken_if;
   logic [31:0] pred_target;
   logic        ex_pred_taken;
   logic [15:0] br_cnt;
   logic [15:0] mispred_cnt;

   int checks;
   int failures;

   branch_predictor #(.IDX_W(IDX_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_pc        (if_pc),
      .if_instr     (if_instr),
      .if_is_branch (if_is_branch),
      .stall        (stall),
      .flush        (flush),
      .taken        (taken),
      .not_taken    (not_taken),
      .pred_taken_if(pred_taken_if),
      .pred_target  (pred_target),
      .ex_pred_taken(ex_pred_taken),
      .br_cnt       (br_cnt),
      .mispred_cnt  (mispred_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      bit v;
      bit br;
      bit pred;
      int idx;
   } slot_t;

   int    m_tab [DEPTH];
   slot_t m_d;
   slot_t m_e;
   int    m_br;
   int    m_mis;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_tab[i] = 1;
      m_d = '{v: 0, br: 0, pred: 0, idx: 0};
      m_e = '{v: 0, br: 0, pred: 0, idx: 0};
      m_br  = 0;
      m_mis = 0;
   endfunction

   function automatic logic [31:0] exp_target(logic [31:0] pc, logic [31:0] ins);
      longint off;
      longint sum;
      off = longint'(ins[15:0]);
      if (off >= 32768) off = off - 65536;
      sum = longint'(pc) + 1 + off;
      return 32'(sum & 64'hFFFF_FFFF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model for the current inputs, advance the
   // model across the next rising edge, and return at the falling edge.
   task automatic step();
      bit    exp_pif;
      bit    exp_ex;
      bit    upd;
      slot_t nd;
      #1;
      exp_pif = if_is_branch && (m_tab[int'(if_pc[5:0])] >= 2);
      exp_ex  = m_e.v && m_e.br && m_e.pred;
      chk("pred_taken_if", {31'b0, pred_taken_if}, {31'b0, exp_pif});
      chk("pred_target", pred_target, exp_target(if_pc, if_instr));
      chk("ex_pred_taken", {31'b0, ex_pred_taken}, {31'b0, exp_ex});
      chk("br_cnt", {16'b0, br_cnt}, 32'(m_br));
      chk("mispred_cnt", {16'b0, mispred_cnt}, 32'(m_mis));

      upd = m_e.v && m_e.br && !stall && (taken != not_taken);
      if (upd) begin
         if (taken) m_tab[m_e.idx] = (m_tab[m_e.idx] + 1 > 3) ? 3 : m_tab[m_e.idx] + 1;
         else       m_tab[m_e.idx] = (m_tab[m_e.idx] - 1 < 0) ? 0 : m_tab[m_e.idx] - 1;
         if (m_br < 65535) m_br++;
         if ((m_e.pred != taken) && (m_mis < 65535)) m_mis++;
      end
      if (flush) begin
         m_d.v = 0;
         m_e.v = 0;
      end else if (!stall) begin
         nd = '{v: 1, br: if_is_branch, pred: exp_pif, idx: int'(if_pc[5:0])};
         m_e = m_d;
         m_d = nd;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] pc, input logic br, input logic st,
                        input logic fl, input logic tk, input logic nt);
      if_pc        = pc;
      if_is_branch = br;
      stall        = st;
      flush        = fl;
      taken        = tk;
      not_taken    = nt;
   endtask

   // ---------------- stimulus ----------------
   int saved;
   int hot;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      if_instr = 32'h0000_0000;
      drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #1;
      chk("reset_pred_if", {31'b0, pred_taken_if}, 32'd0);
      chk("reset_ex_pred", {31'b0, ex_pred_taken}, 32'd0);
      chk("reset_br_cnt", {16'b0, br_cnt}, 32'd0);
      chk("reset_mis_cnt", {16'b0, mispred_cnt}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Warm-up: fetch branch at 0x10, resolve taken two cycles later.
      if_instr = 32'h1234_FFFC;
      drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("warm_pred0", {31'b0, pred_taken_if}, 32'd0);
      chk("warm_target", pred_target, 32'h0000_000D);
      step();
      drive(32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      drive(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("warm_br_cnt", {16'b0, br_cnt}, 32'd1);
      chk("warm_mis_cnt", {16'b0, mispred_cnt}, 32'd1);
      chk("warm_pred1", {31'b0, pred_taken_if}, 32'd1);
      step();

      // Target wrap-around at the top of the address space.
      if_instr = 32'h0000_0001;
      drive(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("wrap_target", pred_target, 32'h0000_0001);
      step();
      drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // Saturation at idx 3: five taken updates, then not-taken steps.
      for (int k = 0; k < 9; k++) begin
         drive(32'h3, (k < 5) || (k >= 7), 1'b0, 1'b0, (k >= 2) && (k <= 6), 1'b0);
         step();
      end
      drive(32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("sat_pred_strong", {31'b0, pred_taken_if}, 32'd1);
      step();
      drive(32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("sat_pred_after_nt", {31'b0, pred_taken_if}, 32'd1);
      step();
      drive(32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      drive(32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("sat_pred_weak_nt", {31'b0, pred_taken_if}, 32'd0);
      step();

      // Flush with branches in D and E: E trains, D is killed.
      drive(32'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      saved = m_br;
      drive(32'h7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      drive(32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("flush_e_trained", {16'b0, br_cnt}, 32'(saved + 1));
      chk("flush_ex_pred", {31'b0, ex_pred_taken}, 32'd0);
      step();
      drive(32'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("flush_no_update", {16'b0, br_cnt}, 32'(saved + 1));
      step();

      // Stall for three cycles with taken asserted, then release.
      drive(32'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(32'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      saved = m_br;
      for (int k = 0; k < 3; k++) begin
         drive(32'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
         step();
      end
      drive(32'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("stall_held_cnt", {16'b0, br_cnt}, 32'(saved));
      step();
      drive(32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("stall_release_cnt", {16'b0, br_cnt}, 32'(saved + 1));
      step();

      // Illegal resolve: both taken and not_taken.
      drive(32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(32'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      saved = m_br;
      drive(32'hE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      drive(32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("illegal_br_cnt", {16'b0, br_cnt}, 32'(saved));
      chk("illegal_pred", {31'b0, pred_taken_if}, 32'd0);
      step();

      // Randomized traffic over a small index window to force aliasing.
      for (int k = 0; k < 1500; k++) begin
         int r;
         if_instr = $urandom();
         r = $urandom_range(0, 9);
         drive(($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 15)),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 6) == 0),
               ($urandom_range(0, 9) == 0), (r <= 3) || (r == 8),
               ((r >= 4) && (r <= 7)) || (r == 8));
         step();
      end

      // Asynchronous reset in the middle of a cycle.
      hot = 0;
      for (int i = 0; i < 16; i++) if (m_tab[i] >= 2) hot = i;
      drive(32'(hot), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_pred_if", {31'b0, pred_taken_if}, 32'd0);
      chk("areset_ex_pred", {31'b0, ex_pred_taken}, 32'd0);
      chk("areset_br_cnt", {16'b0, br_cnt}, 32'd0);
      chk("areset_mis_cnt", {16'b0, mispred_cnt}, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // One taken update per entry: an entry reset to 1 becomes weak-T.
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive(32'(i % DEPTH), (i < DEPTH), 1'b0, 1'b0, (i >= 2), 1'b0);
         step();
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         chk("post_reset_entry", {31'b0, pred_taken_if}, 32'd1);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 6, sets the number of table index bits; the table has 2^IDX_W 2-bit entries.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_pc  in  32  PC of the instruction in IF, word-addressed.
REQ-005 if_instr  in  32  fetched instruction; [15:0] is the branch offset.
REQ-006 if_is_branch  in  1  fetched instruction is a conditional branch.
REQ-007 stall  in  1  pipeline hold; IF/ID and ID/EX do not advance.
REQ-008 flush  in  1  EX changeFlow; kills the IF/ID and ID/EX slots.
REQ-009 taken  in  1  EX-stage branch resolved taken.
REQ-010 not_taken  in  1  EX-stage branch resolved not taken.
REQ-011 pred_taken_if  out  1  IF-stage prediction, used for next-PC select.
REQ-012 pred_target  out  32  if_pc + 1 + sign-extended if_instr[15:0], modulo 2^32.
REQ-013 ex_pred_taken  out  1  prediction carried to EX, driving the EX pred_taken input.
REQ-014 br_cnt  out  16  resolved-branch count.
REQ-015 mispred_cnt  out  16  mispredicted-branch count.

Function
REQ-016 idx = if_pc[IDX_W-1:0].
REQ-017 pred_taken_if = if_is_branch AND table[idx][1], combinational.
REQ-018 Table entries are 2-bit saturating counters: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
REQ-019 Two internal slots, D (IF/ID) and E (ID/EX), each hold {valid, is_branch, pred, idx}.
REQ-020 When stall=0 and flush=0, at each clock edge:
- D loads {1, if_is_branch, pred_taken_if, idx}.
- E loads D.
REQ-021 When stall=1 and flush=0, D and E hold their contents.
REQ-022 When flush=1, D and E clear valid at the clock edge; flush has priority over stall.
REQ-023 ex_pred_taken = E.valid AND E.is_branch AND E.pred.
REQ-024 An update occurs when all of the following hold:
- E.valid=1, E.is_branch=1, stall=0;
- exactly one of taken/not_taken is 1.
REQ-025 On update, table[E.idx] increments with saturation at 3 if taken=1, and decrements with saturation at 0 if not_taken=1.
REQ-026 When taken=not_taken (both 0 or both 1), no table write occurs and neither counter changes.
REQ-027 An update occurs even when flush=1 in the same cycle, because the EX instruction itself is not killed.
REQ-028 On update, br_cnt increments; it saturates at 16'hFFFF.
REQ-029 On update with E.pred != taken, mispred_cnt increments; it saturates at 16'hFFFF.
REQ-030 Same-cycle read and update of the same index: the read returns the pre-update value, with no bypass, and the write lands at the edge.
REQ-031 Table state changes only through REQ-025; there are no other writes.

Reset
REQ-032 When rst_n=0, asynchronously:
- every table entry becomes 2'b01;
- D.valid and E.valid become 0;
- br_cnt and mispred_cnt become 0.
REQ-033 During reset, pred_taken_if=0, ex_pred_taken=0, br_cnt=0 and mispred_cnt=0; pred_target remains combinational.
REQ-034 Reset asserted mid-operation discards in-flight slots; no update occurs in a cycle where rst_n=0.

Verification
REQ-035 Warm-up. After reset, present if_pc=0x10, if_is_branch=1, if_instr[15:0]=0xFFFC. Expect pred_taken_if=0 and pred_target=0x0D. Two cycles later, drive taken=1: table[0x10] becomes 2, br_cnt=1, mispred_cnt=1. The next fetch of 0x10 gives pred_taken_if=1.
REQ-036 Saturation. Apply 5 consecutive taken updates to idx 3: entry equals 3. Then apply 1 not_taken: entry equals 2 and pred_taken_if stays 1.
REQ-037 Flush. A branch is in D and an older branch is in E, with flush=1. The E update is applied. Next cycle E.valid=0 and ex_pred_taken=0, and no update occurs for the flushed branch.
REQ-038 Stall. stall=1 for 3 cycles with taken=1: no table change and br_cnt unchanged. Then release: exactly one update occurs.
REQ-039 Illegal resolve. With taken=1 and not_taken=1 on a valid E branch, the table and both counters are unchanged.
REQ-040 Async reset. Assert rst_n low mid-cycle after 10 updates: all outputs read 0 immediately, with no clock edge required; all entries read 1 after release.
